fft_bitrev_load: RTL and testbench



---
 rtl/fft_bitrev_load.sv | 162 ++++++++++++++++
 tb/tb_fft_bitrev_load.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_load.sv
// Purpose  : loads one frame of N complex samples into the X_R/X_I ping-pong buffer at bit-reversed addresses.
// Latency  : each accepted sample is written exactly one cycle after it is accepted; ap_done comes in the cycle of the final write.
// Backpres.: in_ready is high only while loading, so a stalled producer only delays the frame; ap_done holds until ap_continue.
//
// Ports:
//   ap_clk, ap_rst_n                        clock, async active-low reset
//   ap_start/ap_done/ap_continue/
//   ap_idle/ap_ready                        block-level handshake shared with the butterfly stages
//   in_valid/in_ready/in_real/in_imag/
//   in_last                                 sample stream; in_last marks the producer's final sample
//   Out_R_*, Out_I_*                        write port (address/ce/we/data) into the real and imaginary buffers
//   last_err                                sticky: in_last did not coincide with sample N-1 in the last frame
module fft_bitrev_load #(
    parameter int DATA_W = 32,
    parameter int LOG2N  = 10,
    parameter int N      = 1024
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    input  logic              ap_continue,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    input  logic              in_last,
    output logic [LOG2N-1:0]  Out_R_address0,
    output logic              Out_R_ce0,
    output logic              Out_R_we0,
    output logic [DATA_W-1:0] Out_R_d0,
    output logic [LOG2N-1:0]  Out_I_address0,
    output logic              Out_I_ce0,
    output logic              Out_I_we0,
    output logic [DATA_W-1:0] Out_I_d0,
    output logic              last_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    state_t              state_q, state_d;
    logic [LOG2N-1:0]    cnt_q, cnt_d;
    logic [LOG2N-1:0]    cnt_rev;
    logic                done_reg_q, done_reg_d;
    logic                last_err_q, last_err_d;
    // Write stage: one register slice between the stream and the buffer port.
    logic                wvld_q, wvld_d;
    logic [LOG2N-1:0]    wa_q, wa_d;
    logic [DATA_W-1:0]   wr_q, wr_d;
    logic [DATA_W-1:0]   wi_q, wi_d;
    logic                done_pulse;

    // Bit i of the sample index lands on bit LOG2N-1-i of the buffer address.
    always_comb begin
        cnt_rev = '0;
        for (int i = 0; i < LOG2N; i++) begin
            cnt_rev[LOG2N-1-i] = cnt_q[i];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            done_reg_q <= 1'b0;
            last_err_q <= 1'b0;
            wvld_q     <= 1'b0;
            wa_q       <= '0;
            wr_q       <= '0;
            wi_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_reg_q <= done_reg_d;
            last_err_q <= last_err_d;
            wvld_q     <= wvld_d;
            wa_q       <= wa_d;
            wr_q       <= wr_d;
            wi_q       <= wi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_reg_d = done_reg_q;
        last_err_d = last_err_q;
        wvld_d     = 1'b0;
        wa_d       = wa_q;
        wr_d       = wr_q;
        wi_d       = wi_q;
        in_ready   = 1'b0;
        done_pulse = 1'b0;

        if (ap_continue) begin
            done_reg_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // An unacknowledged done blocks the next frame so the buffer is not overwritten.
                if (ap_start && !done_reg_q) begin
                    state_d    = S_LOAD;
                    cnt_d      = '0;
                    last_err_d = 1'b0;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wvld_d = 1'b1;
                    wa_d   = cnt_rev;
                    wr_d   = in_real;
                    wi_d   = in_imag;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_FLUSH;
                        if (!in_last) begin
                            last_err_d = 1'b1;
                        end
                    end else if (in_last) begin
                        // Short frame: unwritten addresses keep their previous contents.
                        last_err_d = 1'b1;
                        state_d    = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // The final write is on the buffer port during this cycle.
                done_pulse = 1'b1;
                done_reg_d = !ap_continue;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ap_done  = done_pulse | done_reg_q;
    assign ap_ready = done_pulse;
    assign ap_idle  = (state_q == S_IDLE) && !ap_start;
    assign last_err = last_err_q;

    assign Out_R_address0 = wa_q;
    assign Out_R_ce0      = wvld_q;
    assign Out_R_we0      = wvld_q;
    assign Out_R_d0       = wr_q;
    assign Out_I_address0 = wa_q;
    assign Out_I_ce0      = wvld_q;
    assign Out_I_we0      = wvld_q;
    assign Out_I_d0       = wi_q;

endmodule

// File: tb/tb_fft_bitrev_load.sv
// Purpose  : directed bench for fft_bitrev_load with a buffer model fed from the write port.
// Latency  : checks each buffer write lands one cycle after its accepted sample.
// Backpres.: drives the stream with continuous and every-other-cycle valid patterns.
module tb_fft_bitrev_load;

    localparam int DATA_W = 32;
    localparam int LOG2N  = 10;
    localparam int N      = 1024;

    logic              ap_clk;
    logic              ap_rst_n;
    logic              ap_start;
    logic              ap_done;
    logic              ap_continue;
    logic              ap_idle;
    logic              ap_ready;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_real;
    logic [DATA_W-1:0] in_imag;
    logic              in_last;
    logic [LOG2N-1:0]  Out_R_address0;
    logic              Out_R_ce0;
    logic              Out_R_we0;
    logic [DATA_W-1:0] Out_R_d0;
    logic [LOG2N-1:0]  Out_I_address0;
    logic              Out_I_ce0;
    logic              Out_I_we0;
    logic [DATA_W-1:0] Out_I_d0;
    logic              last_err;

    fft_bitrev_load #(.DATA_W(DATA_W), .LOG2N(LOG2N), .N(N)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .ap_continue(ap_continue), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .in_last(in_last),
        .Out_R_address0(Out_R_address0), .Out_R_ce0(Out_R_ce0), .Out_R_we0(Out_R_we0), .Out_R_d0(Out_R_d0),
        .Out_I_address0(Out_I_address0), .Out_I_ce0(Out_I_ce0), .Out_I_we0(Out_I_we0), .Out_I_d0(Out_I_d0),
        .last_err(last_err)
    );

    int errors = 0;
    int checks = 0;

    // Buffer model and write-port monitor state.
    logic [DATA_W-1:0] mem_r [N];
    logic [DATA_W-1:0] mem_i [N];
    int nwr     = 0;
    int lat_bad = 0;
    int cyc     = 0;
    int fire_q[$];

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Samples 1 ns after the falling edge: a visible fire commits at the next rising
    // edge (cyc+1); a visible write must come from the fire at the previous edge (cyc).
    always @(negedge ap_clk) begin
        #1;
        if (ap_rst_n) begin
            if (Out_R_ce0 && Out_R_we0) begin
                mem_r[Out_R_address0] = Out_R_d0;
                mem_i[Out_I_address0] = Out_I_d0;
                nwr++;
                if (!(Out_I_ce0 && Out_I_we0) || Out_I_address0 !== Out_R_address0) lat_bad++;
                if (fire_q.size() == 0) lat_bad++;
                else if (fire_q.pop_front() != cyc) lat_bad++;
            end
            if (in_valid && in_ready) fire_q.push_back(cyc + 1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    function automatic int bitrev(input int k);
        int r = 0;
        int x = k;
        repeat (LOG2N) begin
            r = (r << 1) | (x & 1);
            x = x >> 1;
        end
        return r;
    endfunction

    // Starts a frame and pushes nsamp samples (value base+k / -(base+k)); in_last on index last_at.
    // Returns at the falling edge right after the final accepted sample.
    task automatic send_frame(input int nsamp, input int last_at, input bit toggle,
                              input int base, output int sent);
        int   guard;
        logic fired;
        sent  = 0;
        guard = 0;
        @(negedge ap_clk); ap_start = 1'b1;
        @(negedge ap_clk); ap_start = 1'b0;
        while (sent < nsamp && guard < 5000) begin
            guard++;
            if (toggle && (guard % 2 == 1)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_real  = base + sent;
                in_imag  = -(base + sent);
                in_last  = (sent == last_at);
            end
            fired = in_valid && in_ready;
            @(negedge ap_clk);
            if (fired) sent++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", ap_done); end
        checks++; if (ap_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ap_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if ({Out_R_ce0, Out_R_we0, Out_I_ce0, Out_I_we0} !== 4'b0) begin errors++; $display("FAIL rst_ce_we: got %b want 0000", {Out_R_ce0, Out_R_we0, Out_I_ce0, Out_I_we0}); end
        checks++; if (Out_R_address0 !== '0 || Out_R_d0 !== '0 || Out_I_d0 !== '0) begin errors++; $display("FAIL rst_addr_data: got addr %0d dr %0h di %0h want 0", Out_R_address0, Out_R_d0, Out_I_d0); end
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL rst_idle0: got %b want 1", ap_idle); end
        ap_start = 1'b1; #1;
        checks++; if (ap_idle !== 1'b0) begin errors++; $display("FAIL rst_idle1: got %b want 0", ap_idle); end
        ap_start = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL rst_last_err: got %b want 0", last_err); end
    endtask

    task automatic test_full_frame();
        int n0 = nwr, l0 = lat_bad, sent, bad = 0;
        send_frame(N, N - 1, 1'b0, 0, sent);
        checks++; if (sent !== N) begin errors++; $display("FAIL full_sent: got %0d want %0d", sent, N); end
        checks++; if (ap_done !== 1'b1 || ap_ready !== 1'b1) begin errors++; $display("FAIL full_done_pulse: got done %b ready %b want 1 1", ap_done, ap_ready); end
        checks++; if (Out_R_ce0 !== 1'b1 || Out_R_address0 !== 10'd1023 || Out_R_d0 !== 32'd1023) begin errors++; $display("FAIL full_last_write: got ce %b addr %0d d %0d want 1 1023 1023", Out_R_ce0, Out_R_address0, Out_R_d0); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_flush_rdy: got %b want 0", in_ready); end
        @(negedge ap_clk);
        checks++; if (ap_done !== 1'b0 || ap_ready !== 1'b0) begin errors++; $display("FAIL full_done_clear: got done %b ready %b want 0 0", ap_done, ap_ready); end
        checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL full_last_err: got %b want 0", last_err); end
        checks++; if (mem_r[512] !== 32'd1 || mem_i[512] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL full_k1: got %0h/%0h want 1/ffffffff", mem_r[512], mem_i[512]); end
        checks++; if (mem_r[256] !== 32'd2) begin errors++; $display("FAIL full_k2: got %0d want 2", mem_r[256]); end
        checks++; if (mem_r[1023] !== 32'd1023 || mem_r[0] !== 32'd0) begin errors++; $display("FAIL full_k1023: got %0d/%0d want 1023/0", mem_r[1023], mem_r[0]); end
        for (int k = 0; k < N; k++) begin
            if (mem_r[bitrev(k)] !== 32'(k) || mem_i[bitrev(k)] !== 32'(-k)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_image: got %0d bad entries want 0", bad); end
        checks++; if (nwr - n0 !== N) begin errors++; $display("FAIL full_nwr: got %0d want %0d", nwr - n0, N); end
        checks++; if (lat_bad - l0 !== 0) begin errors++; $display("FAIL full_latency: got %0d bad writes want 0", lat_bad - l0); end
    endtask

    task automatic test_toggle_valid();
        int n0 = nwr, l0 = lat_bad, sent, bad = 0;
        for (int k = 0; k < N; k++) begin
            mem_r[k] = 32'hDEAD_BEEF;
            mem_i[k] = 32'hDEAD_BEEF;
        end
        send_frame(N, N - 1, 1'b1, 0, sent);
        checks++; if (ap_done !== 1'b1) begin errors++; $display("FAIL tog_done: got %b want 1", ap_done); end
        @(negedge ap_clk);
        for (int k = 0; k < N; k++) begin
            if (mem_r[bitrev(k)] !== 32'(k) || mem_i[bitrev(k)] !== 32'(-k)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL tog_image: got %0d bad entries want 0", bad); end
        checks++; if (nwr - n0 !== N) begin errors++; $display("FAIL tog_nwr: got %0d want %0d", nwr - n0, N); end
        checks++; if (lat_bad - l0 !== 0) begin errors++; $display("FAIL tog_latency: got %0d bad writes want 0", lat_bad - l0); end
        checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL tog_last_err: got %b want 0", last_err); end
    endtask

    task automatic test_done_hold();
        int n0, sent, bad = 0;
        ap_continue = 1'b0;
        send_frame(N, N - 1, 1'b0, 0, sent);
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            checks++; if (ap_done !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL hold_cyc%0d: got done %b rdy %b want 1 0", i, ap_done, in_ready); end
            ap_start = 1'b1;
        end
        @(negedge ap_clk);
        checks++; if (ap_done !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL hold_end: got done %b rdy %b want 1 0", ap_done, in_ready); end
        ap_start    = 1'b0;
        ap_continue = 1'b1;
        @(negedge ap_clk);
        checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", ap_done); end
        n0 = nwr;
        send_frame(10, 9, 1'b0, 5000, sent);
        checks++; if (ap_done !== 1'b1) begin errors++; $display("FAIL hold_new_done: got %b want 1", ap_done); end
        @(negedge ap_clk);
        for (int k = 0; k < 10; k++) begin
            if (mem_r[bitrev(k)] !== 32'(5000 + k)) bad++;
        end
        checks++; if (bad !== 0 || nwr - n0 !== 10) begin errors++; $display("FAIL hold_new_frame: got %0d bad, %0d writes want 0, 10", bad, nwr - n0); end
    endtask

    task automatic test_early_last();
        int n0 = nwr, sent, bad = 0;
        send_frame(100, 99, 1'b0, 2000, sent);
        checks++; if (ap_done !== 1'b1 || ap_ready !== 1'b1) begin errors++; $display("FAIL early_done: got done %b ready %b want 1 1", ap_done, ap_ready); end
        checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL early_last_err: got %b want 1", last_err); end
        @(negedge ap_clk);
        checks++; if (nwr - n0 !== 100) begin errors++; $display("FAIL early_nwr: got %0d want 100", nwr - n0); end
        for (int k = 0; k < N; k++) begin
            if (k < 100) begin
                if (mem_r[bitrev(k)] !== 32'(2000 + k) || mem_i[bitrev(k)] !== 32'(-(2000 + k))) bad++;
            end else begin
                if (mem_r[bitrev(k)] !== 32'(k) || mem_i[bitrev(k)] !== 32'(-k)) bad++;
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL early_image: got %0d bad entries want 0", bad); end
        checks++; if (last_err !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL early_sticky: got err %b rdy %b want 1 0", last_err, in_ready); end
    endtask

    task automatic test_no_last();
        int n0 = nwr, sent;
        send_frame(N, -1, 1'b0, 0, sent);
        checks++; if (ap_done !== 1'b1 || last_err !== 1'b1) begin errors++; $display("FAIL nolast_end: got done %b err %b want 1 1", ap_done, last_err); end
        @(negedge ap_clk);
        checks++; if (nwr - n0 !== N || ap_idle !== 1'b1) begin errors++; $display("FAIL nolast_nwr: got %0d writes idle %b want %0d 1", nwr - n0, ap_idle, N); end
    endtask

    task automatic test_reset_mid();
        int sent, done_seen = 0;
        send_frame(300, -1, 1'b0, 0, sent);
        checks++; if (Out_R_ce0 !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_pre: got ce %b rdy %b want 1 1", Out_R_ce0, in_ready); end
        in_valid = 1'b1;
        in_real  = 300;
        in_imag  = -300;
        #2 ap_rst_n = 1'b0;
        #1;
        checks++; if ({Out_R_ce0, Out_R_we0, Out_I_ce0, Out_I_we0} !== 4'b0) begin errors++; $display("FAIL mid_ce_we: got %b want 0000", {Out_R_ce0, Out_R_we0, Out_I_ce0, Out_I_we0}); end
        checks++; if (in_ready !== 1'b0 || ap_done !== 1'b0 || ap_idle !== 1'b1) begin errors++; $display("FAIL mid_state: got rdy %b done %b idle %b want 0 0 1", in_ready, ap_done, ap_idle); end
        in_valid = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (4) begin
            @(negedge ap_clk);
            if (ap_done !== 1'b0 || ap_ready !== 1'b0 || in_ready !== 1'b0 || ap_idle !== 1'b1) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL mid_after: got %0d bad cycles want 0", done_seen); end
    endtask

    initial begin
        ap_rst_n    = 1'b0;
        ap_start    = 1'b0;
        ap_continue = 1'b1;
        in_valid    = 1'b0;
        in_real     = '0;
        in_imag     = '0;
        in_last     = 1'b0;
        test_reset();
        test_full_frame();
        test_toggle_valid();
        test_done_hold();
        test_early_last();
        test_no_last();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
